// File: rtl/bsg_manycore_mem_responder.sv
// Manycore endpoint memory responder: byte-masked SRAM that serves load/store packets and returns one response each.
// Optional address-error reporting is enabled by defining BSG_MANYCORE_MEM_RESPONDER_ERR_EN.
module bsg_manycore_mem_responder #(
  parameter int unsigned x_cord_width_p = 4,
  parameter int unsigned y_cord_width_p = 4,
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned addr_width_p   = 32,
  parameter int unsigned mem_els_p      = 16,
  // request (LSB first): dst_x, dst_y, src_x, src_y, payload, mask, op (1 = store), addr
  localparam int unsigned packet_width_lp =
    2 * (x_cord_width_p + y_cord_width_p) + data_width_p + data_width_p / 8 + 1 + addr_width_p,
  // return (LSB first): dst_x, dst_y, data, type
  localparam int unsigned return_packet_width_lp =
    x_cord_width_p + y_cord_width_p + data_width_p + 2
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [packet_width_lp-1:0]        in_packet_i,
  input  logic                              in_v_i,
  output logic                              in_yumi_o,
  output logic [return_packet_width_lp-1:0] returning_data_o,
  output logic                              returning_v_o,
  input  logic                              returning_ready_i,
  output logic                              err_o
);

  localparam int unsigned XW      = x_cord_width_p;
  localparam int unsigned YW      = y_cord_width_p;
  localparam int unsigned DW      = data_width_p;
  localparam int unsigned AW      = addr_width_p;
  localparam int unsigned MW      = data_width_p / 8;
  localparam int unsigned LG      = $clog2(mem_els_p);
  localparam int unsigned SRCX_LO = XW + YW;
  localparam int unsigned SRCY_LO = 2 * XW + YW;
  localparam int unsigned DATA_LO = 2 * XW + 2 * YW;
  localparam int unsigned MASK_LO = DATA_LO + DW;
  localparam int unsigned OP_BIT  = MASK_LO + MW;
  localparam int unsigned ADDR_LO = OP_BIT + 1;

  logic [DW-1:0] r_mem [mem_els_p];
  logic [DW-1:0] r_rdata;
  logic          r_v;
  logic [1:0]    r_type;
  logic [XW-1:0] r_dst_x;
  logic [YW-1:0] r_dst_y;

  logic [XW-1:0] w_src_x;
  logic [YW-1:0] w_src_y;
  logic [DW-1:0] w_payload;
  logic [MW-1:0] w_mask;
  logic          w_store;
  logic [AW-1:0] w_addr;
  logic [LG-1:0] w_idx;
  logic          w_in_range;
  logic          w_yumi;
  logic [1:0]    w_type;
  logic          w_unused_dst;

  assign w_src_x      = in_packet_i[SRCX_LO +: XW];
  assign w_src_y      = in_packet_i[SRCY_LO +: YW];
  assign w_payload    = in_packet_i[DATA_LO +: DW];
  assign w_mask       = in_packet_i[MASK_LO +: MW];
  assign w_store      = in_packet_i[OP_BIT];
  assign w_addr       = in_packet_i[ADDR_LO +: AW];
  assign w_idx        = w_addr[LG-1:0];
  assign w_in_range   = (w_addr < AW'(mem_els_p));
  assign w_unused_dst = ^in_packet_i[SRCX_LO-1:0];

  // Accept whenever the return slot is empty or drains this cycle.
  assign w_yumi    = in_v_i & reset_n_i & (~r_v | returning_ready_i);
  assign in_yumi_o = w_yumi;

`ifdef BSG_MANYCORE_MEM_RESPONDER_ERR_EN
  assign w_type = w_in_range ? {1'b0, ~w_store} : 2'd2;
`else
  assign w_type = {1'b0, ~w_store};
`endif

  // SRAM array and its read register; only touched on yumi so a stalled return keeps its data.
  always_ff @(posedge clk_i) begin
    if (w_yumi) begin
      if (w_store && w_in_range) begin
        for (int unsigned b = 0; b < MW; b++) begin
          if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_payload[8*b +: 8];
        end
      end
      r_rdata <= (!w_store && w_in_range) ? r_mem[w_idx] : '0;
    end
  end

  // Return slot control and header fields.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_v     <= 1'b0;
      r_type  <= 2'd0;
      r_dst_x <= '0;
      r_dst_y <= '0;
    end else if (w_yumi) begin
      r_v     <= 1'b1;
      r_type  <= w_type;
      r_dst_x <= w_src_x;
      r_dst_y <= w_src_y;
    end else if (returning_ready_i) begin
      r_v     <= 1'b0;
    end
  end

`ifdef BSG_MANYCORE_MEM_RESPONDER_ERR_EN
  logic r_err;

  // Sticky until reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                  r_err <= 1'b0;
    else if (w_yumi && !w_in_range)  r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign returning_v_o    = r_v;
  assign returning_data_o = {r_type, r_rdata, r_dst_y, r_dst_x};

endmodule

// File: doc/bsg_manycore_mem_responder.md
BSG_MANYCORE_MEM_RESPONDER -- requirements
Module: bsg_manycore_mem_responder

Interface
REQ-001 SHALL have parameter x_cord_width_p, default "inv", meaning X coordinate width.
REQ-002 SHALL have parameter y_cord_width_p, default "inv", meaning Y coordinate width.
REQ-003 SHALL have parameter data_width_p, default 32, meaning word width; it SHALL be a multiple of 8.
REQ-004 SHALL have parameter addr_width_p, default 32, meaning word-address width.
REQ-005 SHALL have parameter mem_els_p, default "inv", meaning number of internal SRAM words; it SHALL be a power of 2 and at least 2.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port in_packet_i, input, packet_width_lp: request packet from the endpoint request FIFO, laid out as bsg_manycore_packet_s.
REQ-009 SHALL have port in_v_i, input, 1 bit: request valid.
REQ-010 SHALL have port in_yumi_o, output, 1 bit: request consumed this cycle.
REQ-011 SHALL have port returning_data_o, output, return_packet_width_lp: return packet, laid out as bsg_manycore_return_packet_s.
REQ-012 SHALL have port returning_v_o, output, 1 bit: return packet valid.
REQ-013 SHALL have port returning_ready_i, input, 1 bit: the network accepts the return packet.
REQ-014 SHALL have port err_o, output, 1 bit: sticky address-error flag.

Function
REQ-015 in_yumi_o SHALL equal in_v_i & reset_n_i & (~ret_v_r | returning_ready_i); it SHALL never assert when in_v_i is low.
REQ-016 On yumi, a store (op=store) SHALL write the payload to SRAM word addr[log2(mem_els_p)-1:0], byte-masked by the packet mask, in that same cycle.
REQ-017 On yumi, a load SHALL issue a synchronous SRAM read; the data SHALL appear in returning_data_o exactly 1 cycle later.
REQ-018 The return register SHALL load on yumi, with returning_v_o=1 from the next cycle.
  - Return fields: dst_x/dst_y = request src_x/src_y.
  - Type: 0 = store ack (data 0), 1 = load (data = SRAM word).
REQ-019 While returning_v_o=1 and returning_ready_i=0, returning_data_o SHALL hold stable and no SRAM access SHALL occur, so the SRAM output is preserved.
REQ-020 With in_v_i and returning_ready_i held high, throughput SHALL be one request per cycle; returning_v_o SHALL fall the cycle after returning_ready_i is high with no new yumi.
REQ-021 A store followed by a load to the same address on consecutive cycles SHALL return the newly stored data (write-then-read ordering).
REQ-022 Out-of-range request (addr >= mem_els_p): a store SHALL be dropped with no SRAM write; a load SHALL return data 0; a return packet SHALL still be produced.
REQ-023 Return packets SHALL be issued in request order; no request SHALL be dropped, duplicated or reordered.

Reset
REQ-024 While reset_n_i=0 at a clock edge, the block SHALL clear returning_v_o, in_yumi_o and err_o to 0; a pending return SHALL be discarded.
REQ-025 SRAM contents SHALL be undefined after reset and SHALL NOT be cleared.
REQ-026 The first yumi SHALL be possible in the first cycle with reset_n_i=1.

Configuration
REQ-027 Macro BSG_MANYCORE_MEM_RESPONDER_ERR_EN defined: an out-of-range request SHALL set err_o (sticky until reset) and return type 2 (error) in place of 0 or 1.
REQ-028 Macro BSG_MANYCORE_MEM_RESPONDER_ERR_EN undefined: err_o SHALL be tied 0, and out-of-range requests SHALL return normal types per REQ-022.

Verification
REQ-029 Store 0xDEADBEEF, mask 4'b1111, addr 5, src (2,3), ready=1 -> next cycle returning_v_o=1, type 0, dst (2,3), data 0.
REQ-030 Store 0x11223344 mask 4'b0101 to addr 7 (previously 0xAAAAAAAA), then load addr 7 on the next cycle -> load return data 0xAA22AA44.
REQ-031 Load in flight, hold returning_ready_i=0 for 5 cycles with in_v_i=1 -> in_yumi_o=0 and returning_data_o stable for all 5 cycles; on ready=1 the packet retires and the next request yumis in the same cycle.
REQ-032 Back-to-back 8 loads with ready=1 -> 8 yumis in 8 cycles, returns in order one per cycle, latency 1.
REQ-033 Load addr mem_els_p+1 -> data 0.
  - With the macro: type 2 and err_o=1, held high until reset.
  - Without the macro: type 1 and err_o=0.
REQ-034 Assert reset_n_i=0 while returning_v_o=1 and ready=0 -> next cycle returning_v_o=0 and err_o=0; no stale return appears after reset is released.
